fifo_sync: RTL
==============

# fifo_sync

Parametrised single-clock first-word-fall-through FIFO with internal two-port storage, occupancy count, programmable almost-full/almost-empty flags and synchronous flush. It is the standard buffering element between Bootstrap producer/consumer units. It replaces bare memory-plus-external-pointer arrangements with a self-contained, handshake-safe queue.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDRESS_WIDTH, 6, log2 of depth; DEPTH = 2**ADDRESS_WIDTH
- AFULL_THRESH, 2**ADDRESS_WIDTH-4, afull_o asserted when count >= this value
- AEMPTY_THRESH, 4, aempty_o asserted when count <= this value
- fifosync_clk_i  in  1  single clock, all state on rising edge
- fifosync_rstn_i  in  1  asynchronous, active-low reset
- fifosync_clear_i  in  1  synchronous flush
- fifosync_push_i  in  1  write request
- fifosync_data_i  in  DATA_WIDTH  write data
- fifosync_pop_i  in  1  read request; consumes the head word
- fifosync_data_o  out  DATA_WIDTH  head word, valid whenever empty_o=0
- fifosync_full_o  out  1  count == DEPTH
- fifosync_empty_o  out  1  count == 0
- fifosync_afull_o  out  1  almost full
- fifosync_aempty_o  out  1  almost empty
- fifosync_count_o  out  ADDRESS_WIDTH+1  occupancy, 0..DEPTH
- fifosync_ovf_o, fifosync_udf_o  out  1 each  error flags (see Configuration)

## Operation
- Write and read pointers are ADDRESS_WIDTH+1 bits wide. The low bits index storage; the MSB is the wrap bit.
- full: low bits are equal and MSBs differ. empty: pointers are equal.
- count = wptr - rptr, modulo 2**(ADDRESS_WIDTH+1).
- Accepted push (push_i & ~full_o): store data_i at wptr, then wptr+1.
- Accepted pop (pop_i & ~empty_o): rptr+1.
- Push when full: word dropped, no state change. Pop when empty: ignored.
- Push+pop when empty: only the push is accepted; count becomes 1.
- Push+pop when full: both are accepted; count stays DEPTH. The old head is read before the edge, and the new word lands in the freed slot.
- Push+pop otherwise: both are accepted; count is unchanged.
- clear_i overrides push and pop. Pointers go to 0 and storage contents are not erased.
- Pointers wrap naturally at 2**(ADDRESS_WIDTH+1); there are no special cases.
- Storage has no reset and is combinationally read at the rptr low bits.

## Timing
- Reset values: pointers 0, count_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, ovf_o=0, udf_o=0.
- data_o is don't-care while empty_o=1.
- Flags and count are decoded from registered pointers, so they update in the cycle after the accepting edge.
- Push-to-data_o latency is 1 cycle. A word pushed at edge N is on data_o, with empty_o=0, after edge N.
- Pop at edge N presents the next word after edge N, with zero bubble.
- Reset assertion mid-operation immediately empties the FIFO (asynchronous). Deassertion is synchronised externally.
- clear_i takes effect at the next edge; all flags show their reset values the following cycle.

## Configuration
- FIFOSYNC_STICKY_ERR_EN defined:
  - ovf_o sets on push_i & full_o; udf_o sets on pop_i & empty_o (the same push+pop exception applies).
  - Both flags are sticky until reset or clear_i.
- FIFOSYNC_STICKY_ERR_EN undefined: ovf_o and udf_o are tied to 0 and their logic is absent.

## Structure
- Shared package fifosync_pkg holds the default width/depth constants and the pointer-compare helpers (full, empty, count functions).
- One sub-module, fifosync_mem: simple two-port array with synchronous write and asynchronous read. It has no reset and is parametrised on ADDRESS_WIDTH and DATA_WIDTH.
- The top level holds pointers, flag decode and error logic.

## Test plan
- Reset with defaults -> empty_o=1, aempty_o=1, count_o=0, full_o=0, ovf_o=0.
- Push 0xA0000000..0xA000003F (64 words) -> full_o=1 and count_o=64 after the last edge. afull_o rises when count reaches 60, aempty_o falls when count reaches 5. A 65th push of 0xDEAD leaves count_o=64 and sets ovf_o (with macro).
- Pop all 64 words -> data_o sequence exactly matches the push order, empty_o=1 after the last pop. A further pop sets udf_o and leaves count_o=0.
- Fill to 64, then push+pop 200 consecutive cycles -> count_o stays 64 and order is preserved across multiple pointer wraps.
- Empty FIFO, push 0x1234 with pop=1 in the same cycle -> count_o=1, data_o=0x1234 next cycle, udf_o stays 0.
- Count 10, assert clear_i together with push -> count_o=0 and empty_o=1 next cycle, push discarded. Asynchronous reset pulse mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifosync_pkg.sv
// Shared constants and pointer-compare helpers for the fifo_sync queue.
// Helpers take zero-extended pointers plus the address width so any depth can share them.
package fifosync_pkg;

    localparam int FIFOSYNC_DATA_WIDTH = 32;
    localparam int FIFOSYNC_ADDR_WIDTH = 6;
    localparam int PTR_EXT_W           = 32;

    typedef logic [PTR_EXT_W-1:0] ptr_ext_t;

    function automatic ptr_ext_t ptr_mask(input int aw);
        return (ptr_ext_t'(1) << aw) - ptr_ext_t'(1);
    endfunction

    // Occupancy is the pointer difference modulo 2**(aw+1).
    function automatic ptr_ext_t ptr_count(input ptr_ext_t w, input ptr_ext_t r, input int aw);
        return (w - r) & ptr_mask(aw + 1);
    endfunction

    function automatic logic ptr_empty(input ptr_ext_t w, input ptr_ext_t r);
        return w == r;
    endfunction

    // A difference of exactly 2**aw means equal low bits with opposite wrap bits.
    function automatic logic ptr_full(input ptr_ext_t w, input ptr_ext_t r, input int aw);
        return ptr_count(w, r, aw) == (ptr_ext_t'(1) << aw);
    endfunction

endpackage

// File: rtl/fifosync_mem.sv
// Two-port storage: synchronous write, asynchronous read, no reset.
// Zero read latency; no backpressure of its own.
module fifosync_mem #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic [ADDRESS_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO with count, almost flags, flush; sticky ovf/udf under FIFOSYNC_STICKY_ERR_EN.
// Push-to-head latency 1 cycle; pushes while full are dropped unless paired with a pop.
module fifo_sync
    import fifosync_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFOSYNC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = FIFOSYNC_ADDR_WIDTH,
    parameter int AFULL_THRESH  = 2**ADDRESS_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                   fifosync_clk_i,
    input  logic                   fifosync_rstn_i,
    input  logic                   fifosync_clear_i,
    input  logic                   fifosync_push_i,
    input  logic [DATA_WIDTH-1:0]  fifosync_data_i,
    input  logic                   fifosync_pop_i,
    output logic [DATA_WIDTH-1:0]  fifosync_data_o,
    output logic                   fifosync_full_o,
    output logic                   fifosync_empty_o,
    output logic                   fifosync_afull_o,
    output logic                   fifosync_aempty_o,
    output logic [ADDRESS_WIDTH:0] fifosync_count_o,
    output logic                   fifosync_ovf_o,
    output logic                   fifosync_udf_o
);

    typedef logic [ADDRESS_WIDTH:0] ptr_t;

    localparam ptr_t AFULL_T  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AEMPTY_T = ptr_t'(AEMPTY_THRESH);

    ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
    ptr_t count;
    logic full, empty, push_acc, pop_acc;

    assign count = ptr_t'(ptr_count(ptr_ext_t'(wptr_q), ptr_ext_t'(rptr_q), ADDRESS_WIDTH));
    assign full  = ptr_full(ptr_ext_t'(wptr_q), ptr_ext_t'(rptr_q), ADDRESS_WIDTH);
    assign empty = ptr_empty(ptr_ext_t'(wptr_q), ptr_ext_t'(rptr_q));

    // A pop alongside a push while full frees the slot the push lands in.
    assign push_acc = fifosync_push_i & (~full | fifosync_pop_i);
    assign pop_acc  = fifosync_pop_i & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (fifosync_clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + ptr_t'(1);
            if (pop_acc)  rptr_d = rptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge fifosync_clk_i or negedge fifosync_rstn_i) begin
        if (!fifosync_rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifosync_mem #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_mem (
        .clk_i   (fifosync_clk_i),
        .we_i    (push_acc & ~fifosync_clear_i),
        .waddr_i (wptr_q[ADDRESS_WIDTH-1:0]),
        .wdata_i (fifosync_data_i),
        .raddr_i (rptr_q[ADDRESS_WIDTH-1:0]),
        .rdata_o (fifosync_data_o)
    );

    assign fifosync_count_o  = count;
    assign fifosync_full_o   = full;
    assign fifosync_empty_o  = empty;
    assign fifosync_afull_o  = count >= AFULL_T;
    assign fifosync_aempty_o = count <= AEMPTY_T;

`ifdef FIFOSYNC_STICKY_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (fifosync_push_i & full & ~fifosync_pop_i);
        udf_d = udf_q | (fifosync_pop_i & empty & ~fifosync_push_i);
        if (fifosync_clear_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge fifosync_clk_i or negedge fifosync_rstn_i) begin
        if (!fifosync_rstn_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign fifosync_ovf_o = ovf_q;
    assign fifosync_udf_o = udf_q;
`else
    assign fifosync_ovf_o = 1'b0;
    assign fifosync_udf_o = 1'b0;
`endif

endmodule
